// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: registered one-hot select for a shared-bus Mux, grant held until owner releases.
// Optional watchdog revoke of stalled grants is enabled with `define ARBITER_TIMEOUT_EN.
module round_robin_arbiter #(
  parameter int INPUTS         = 4,
  parameter int INDEX_WIDTH    = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INPUTS-1:0]      request,
  input  logic                   busAck,
  output logic [INPUTS-1:0]      select,
  output logic [INPUTS-1:0]      requestAck,
  output logic [INDEX_WIDTH-1:0] owner,
  output logic                   busy,
  output logic                   timeout
);

  typedef enum logic [1:0] {
    IDLE,
    GRANTED,
    RELEASE
  } state_t;

  state_t                 state, state_next;
  logic [INPUTS-1:0]      select_next;
  logic [INDEX_WIDTH-1:0] owner_next;
  logic [INDEX_WIDTH-1:0] last_owner, last_owner_next;
  logic                   timeout_next;
  logic                   owner_holds;
  logic                   wd_expire;
  logic                   found_hi, found_lo;
  logic [INDEX_WIDTH-1:0] winner_hi, winner_lo, winner;

  if (INPUTS < 2 || INPUTS > 8) begin : g_bad_inputs
    $error("round_robin_arbiter: INPUTS must be 2..8");
  end
  if ((1 << INDEX_WIDTH) < INPUTS) begin : g_bad_index_width
    $error("round_robin_arbiter: INDEX_WIDTH too small for INPUTS");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("round_robin_arbiter: TIMEOUT_CYCLES must be 1..65535");
  end

  assign owner_holds = |(request & select);
  assign requestAck  = select & {INPUTS{busAck}};
  assign busy        = |select;

  // Rotating priority: lowest requester above last_owner wins, otherwise wrap to lowest overall.
  always_comb begin
    found_hi  = 1'b0;
    found_lo  = 1'b0;
    winner_hi = '0;
    winner_lo = '0;
    for (int j = 0; j < INPUTS; j++) begin
      if (request[j] && !found_hi && (j > int'(last_owner))) begin
        found_hi  = 1'b1;
        winner_hi = INDEX_WIDTH'(j);
      end
      if (request[j] && !found_lo) begin
        found_lo  = 1'b1;
        winner_lo = INDEX_WIDTH'(j);
      end
    end
    winner = found_hi ? winner_hi : winner_lo;
  end

`ifdef ARBITER_TIMEOUT_EN
  logic [15:0] wd_count;

  assign wd_expire = !busAck && (wd_count == 16'(TIMEOUT_CYCLES - 1));

  // Idle cycles (outside GRANTED) leave the counter at zero, so each grant starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_count <= '0;
    end else if (state != GRANTED || busAck) begin
      wd_count <= '0;
    end else begin
      wd_count <= wd_count + 16'd1;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_next      = state;
    select_next     = select;
    owner_next      = owner;
    last_owner_next = last_owner;
    timeout_next    = 1'b0;
    case (state)
      IDLE: begin
        if (|request) begin
          state_next  = GRANTED;
          select_next = {{(INPUTS-1){1'b0}}, 1'b1} << winner;
          owner_next  = winner;
        end
      end
      GRANTED: begin
        if (!owner_holds || wd_expire) begin
          state_next      = RELEASE;
          select_next     = '0;
          owner_next      = '0;
          last_owner_next = owner;
          timeout_next    = owner_holds;
        end
      end
      RELEASE: begin
        state_next = IDLE;
      end
      default: begin
        state_next  = IDLE;
        select_next = '0;
        owner_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      select     <= '0;
      owner      <= '0;
      last_owner <= INDEX_WIDTH'(INPUTS - 1);
      timeout    <= 1'b0;
    end else begin
      state      <= state_next;
      select     <= select_next;
      owner      <= owner_next;
      last_owner <= last_owner_next;
      timeout    <= timeout_next;
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed self-checking bench for round_robin_arbiter (4 requesters, watchdog limit 4 when enabled).
module tb_round_robin_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] request;
  logic       busAck;
  logic [3:0] select;
  logic [3:0] requestAck;
  logic [2:0] owner;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_fails  = 0;

  round_robin_arbiter #(
    .INPUTS(4),
    .INDEX_WIDTH(3),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .request(request),
    .busAck(busAck),
    .select(select),
    .requestAck(requestAck),
    .owner(owner),
    .busy(busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    request = 4'b0000;
    busAck  = 1'b0;
    step();
    step();
    n_checks++;
    if (select !== 4'b0000) begin
      n_fails++;
      $display("[TB] FAIL reset_select: got %b expected %b", select, 4'b0000);
    end
    n_checks++;
    if (owner !== 3'd0) begin
      n_fails++;
      $display("[TB] FAIL reset_owner: got %0d expected %0d", owner, 0);
    end
    n_checks++;
    if ({busy, timeout} !== 2'b00) begin
      n_fails++;
      $display("[TB] FAIL reset_busy_timeout: got %b expected %b", {busy, timeout}, 2'b00);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_grant();
    request = 4'b0001;
    step();
    n_checks++;
    if ({select, owner, busy} !== {4'b0001, 3'd0, 1'b1}) begin
      n_fails++;
      $display("[TB] FAIL single_grant: got sel=%b own=%0d busy=%b expected sel=0001 own=0 busy=1",
               select, owner, busy);
    end
    step();
    step();
    n_checks++;
    if (select !== 4'b0001) begin
      n_fails++;
      $display("[TB] FAIL single_hold: got %b expected %b", select, 4'b0001);
    end
    request = 4'b0000;
    step();
    n_checks++;
    if ({select, owner, busy} !== {4'b0000, 3'd0, 1'b0}) begin
      n_fails++;
      $display("[TB] FAIL single_release: got sel=%b own=%0d busy=%b expected sel=0000 own=0 busy=0",
               select, owner, busy);
    end
    step();
    n_checks++;
    if (select !== 4'b0000) begin
      n_fails++;
      $display("[TB] FAIL single_idle: got %b expected %b", select, 4'b0000);
    end
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_sel;
    pulse_reset();
    request = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_sel = 4'b0001 << exp_order[k];
      step();
      n_checks++;
      if ({select, owner} !== {exp_sel, 3'(exp_order[k])}) begin
        n_fails++;
        $display("[TB] FAIL rr_grant_%0d: got sel=%b own=%0d expected sel=%b own=%0d",
                 k, select, owner, exp_sel, exp_order[k]);
      end
      step();
      request = 4'b1111 & ~exp_sel;
      step();
      n_checks++;
      if ({select, busy} !== {4'b0000, 1'b0}) begin
        n_fails++;
        $display("[TB] FAIL rr_gap_%0d: got sel=%b busy=%b expected sel=0000 busy=0", k, select, busy);
      end
      request = 4'b1111;
      step();
      n_checks++;
      if (select !== 4'b0000) begin
        n_fails++;
        $display("[TB] FAIL rr_idle_%0d: got %b expected %b", k, select, 4'b0000);
      end
    end
    request = 4'b0000;
    step();
    step();
    step();
  endtask

  task automatic test_no_preempt();
    request = 4'b0100;
    step();
    n_checks++;
    if ({select, owner} !== {4'b0100, 3'd2}) begin
      n_fails++;
      $display("[TB] FAIL np_grant: got sel=%b own=%0d expected sel=0100 own=2", select, owner);
    end
    request = 4'b1100;
    step();
    step();
    step();
    n_checks++;
    if (select !== 4'b0100) begin
      n_fails++;
      $display("[TB] FAIL np_hold: got %b expected %b", select, 4'b0100);
    end
    request = 4'b1000;
    step();
    n_checks++;
    if (select !== 4'b0000) begin
      n_fails++;
      $display("[TB] FAIL np_release: got %b expected %b", select, 4'b0000);
    end
    step();
    step();
    n_checks++;
    if ({select, owner} !== {4'b1000, 3'd3}) begin
      n_fails++;
      $display("[TB] FAIL np_next: got sel=%b own=%0d expected sel=1000 own=3", select, owner);
    end
    request = 4'b0000;
    step();
    step();
  endtask

  task automatic test_bus_ack();
    request = 4'b0010;
    step();
    n_checks++;
    if (select !== 4'b0010) begin
      n_fails++;
      $display("[TB] FAIL ack_grant: got %b expected %b", select, 4'b0010);
    end
    busAck = 1'b1;
    #1;
    n_checks++;
    if (requestAck !== 4'b0010) begin
      n_fails++;
      $display("[TB] FAIL ack_route: got %b expected %b", requestAck, 4'b0010);
    end
    step();
    busAck = 1'b0;
    #1;
    n_checks++;
    if ({requestAck, select} !== {4'b0000, 4'b0010}) begin
      n_fails++;
      $display("[TB] FAIL ack_drop: got ack=%b sel=%b expected ack=0000 sel=0010", requestAck, select);
    end
    request = 4'b0000;
    step();
    step();
    busAck = 1'b1;
    #1;
    n_checks++;
    if (requestAck !== 4'b0000) begin
      n_fails++;
      $display("[TB] FAIL ack_idle: got %b expected %b", requestAck, 4'b0000);
    end
    busAck = 1'b0;
  endtask

  task automatic test_async_reset();
    request = 4'b0100;
    step();
    n_checks++;
    if (select !== 4'b0100) begin
      n_fails++;
      $display("[TB] FAIL arst_grant: got %b expected %b", select, 4'b0100);
    end
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({select, owner, busy} !== {4'b0000, 3'd0, 1'b0}) begin
      n_fails++;
      $display("[TB] FAIL arst_async: got sel=%b own=%0d busy=%b expected sel=0000 own=0 busy=0",
               select, owner, busy);
    end
    #2;
    rst     = 1'b0;
    request = 4'b1111;
    step();
    n_checks++;
    if ({select, owner} !== {4'b0001, 3'd0}) begin
      n_fails++;
      $display("[TB] FAIL arst_first: got sel=%b own=%0d expected sel=0001 own=0", select, owner);
    end
    request = 4'b0000;
    step();
    step();
  endtask

  task automatic test_simultaneous();
    request = 4'b0101;
    step();
    n_checks++;
    if ({select, owner} !== {4'b0100, 3'd2}) begin
      n_fails++;
      $display("[TB] FAIL sim_rotate: got sel=%b own=%0d expected sel=0100 own=2", select, owner);
    end
    request = 4'b0110;
    step();
    request = 4'b0100;
    step();
    request = 4'b0000;
    step();
    step();
    step();
    n_checks++;
    if (select !== 4'b0000) begin
      n_fails++;
      $display("[TB] FAIL sim_dropped_not_latched: got %b expected %b", select, 4'b0000);
    end
    request = 4'b0011;
    step();
    n_checks++;
    if ({select, owner} !== {4'b0001, 3'd0}) begin
      n_fails++;
      $display("[TB] FAIL sim_wrap: got sel=%b own=%0d expected sel=0001 own=0", select, owner);
    end
    request = 4'b0000;
    step();
    step();
  endtask

  task automatic test_timeout();
    pulse_reset();
    request = 4'b0011;
    step();
    n_checks++;
    if ({select, timeout} !== {4'b0001, 1'b0}) begin
      n_fails++;
      $display("[TB] FAIL to_grant: got sel=%b to=%b expected sel=0001 to=0", select, timeout);
    end
`ifdef ARBITER_TIMEOUT_EN
    step();
    step();
    step();
    n_checks++;
    if ({select, timeout} !== {4'b0001, 1'b0}) begin
      n_fails++;
      $display("[TB] FAIL to_before: got sel=%b to=%b expected sel=0001 to=0", select, timeout);
    end
    step();
    n_checks++;
    if ({select, timeout} !== {4'b0000, 1'b1}) begin
      n_fails++;
      $display("[TB] FAIL to_revoke: got sel=%b to=%b expected sel=0000 to=1", select, timeout);
    end
    step();
    n_checks++;
    if ({select, timeout} !== {4'b0000, 1'b0}) begin
      n_fails++;
      $display("[TB] FAIL to_pulse_end: got sel=%b to=%b expected sel=0000 to=0", select, timeout);
    end
    step();
    n_checks++;
    if ({select, owner} !== {4'b0010, 3'd1}) begin
      n_fails++;
      $display("[TB] FAIL to_next: got sel=%b own=%0d expected sel=0010 own=1", select, owner);
    end
`else
    for (int c = 0; c < 8; c++) step();
    n_checks++;
    if ({select, timeout} !== {4'b0001, 1'b0}) begin
      n_fails++;
      $display("[TB] FAIL to_hold_forever: got sel=%b to=%b expected sel=0001 to=0", select, timeout);
    end
`endif
    request = 4'b0000;
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin();
    test_no_preempt();
    test_bus_ack();
    test_async_reset();
    test_simultaneous();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
